// File: rtl/one_hot_encoder_stream.sv
// ============================================================================
// Module   : one_hot_encoder_stream
// Desc     : Valid/ready one-hot encoder with a 2-entry output FIFO and a
//            saturating out-of-range counter. Thermometer mode is built only
//            when ONE_HOT_ENC_THERMO_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module one_hot_encoder_stream #(
    parameter int OUTPUT_WIDTH  = 16,
    parameter int INPUT_WIDTH   = $clog2(OUTPUT_WIDTH),
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [INPUT_WIDTH-1:0]   value_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     mode_i,
    input  logic                     en_out_i,
    output logic [OUTPUT_WIDTH-1:0]  code_o,
    output logic                     oor_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    input  logic                     clr_err_i,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                   state;
    logic [OUTPUT_WIDTH-1:0]  head_code;
    logic [OUTPUT_WIDTH-1:0]  tail_code;
    logic                     head_oor;
    logic                     tail_oor;
    logic [ERR_CNT_WIDTH-1:0] err_cnt;

    logic [31:0]              value_ext;
    logic                     enc_oor;
    logic [OUTPUT_WIDTH-1:0]  enc_code;
    logic                     push;
    logic                     pop;

    assign value_ext = 32'(value_i);
    assign enc_oor   = (value_ext >= 32'(OUTPUT_WIDTH));

`ifdef ONE_HOT_ENC_THERMO_EN
    always_comb begin
        enc_code = '0;
        for (int i = 0; i < OUTPUT_WIDTH; i++) begin
            enc_code[i] = mode_i ? (32'(i) <= value_ext) : (32'(i) == value_ext);
        end
        if (enc_oor || !en_out_i) begin
            enc_code = '0;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode_i;

    always_comb begin
        enc_code = '0;
        for (int i = 0; i < OUTPUT_WIDTH; i++) begin
            enc_code[i] = (32'(i) == value_ext);
        end
        if (enc_oor || !en_out_i) begin
            enc_code = '0;
        end
    end
`endif

    // Handshake decode depends only on the state register, never on ready_i.
    assign ready_o = (state != FULL);
    assign valid_o = (state != EMPTY);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    assign code_o    = head_code;
    assign oor_o     = head_oor;
    assign err_cnt_o = err_cnt;

    // Head registers are zeroed whenever the buffer drains so outputs read 0 when idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= EMPTY;
            head_code <= '0;
            head_oor  <= 1'b0;
            tail_code <= '0;
            tail_oor  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_code <= enc_code;
                        head_oor  <= enc_oor;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_code <= enc_code;
                        head_oor  <= enc_oor;
                    end else if (push) begin
                        tail_code <= enc_code;
                        tail_oor  <= enc_oor;
                        state     <= FULL;
                    end else if (pop) begin
                        head_code <= '0;
                        head_oor  <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_code <= tail_code;
                        head_oor  <= tail_oor;
                        tail_code <= '0;
                        tail_oor  <= 1'b0;
                        state     <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt <= '0;
        end else if (clr_err_i) begin
            err_cnt <= '0;
        end else if (push && enc_oor && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_one_hot_encoder_stream.sv
// ============================================================================
// Module   : tb_one_hot_encoder_stream
// Desc     : Self-checking bench for one_hot_encoder_stream (12-bit code,
//            2-bit error counter) against a queue-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_one_hot_encoder_stream;

    localparam int OW = 12;
    localparam int IW = 4;
    localparam int EW = 2;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [IW-1:0] value_i;
    logic          valid_i;
    logic          ready_o;
    logic          mode_i;
    logic          en_out_i;
    logic [OW-1:0] code_o;
    logic          oor_o;
    logic          valid_o;
    logic          ready_i;
    logic          clr_err_i;
    logic [EW-1:0] err_cnt_o;

    one_hot_encoder_stream #(
        .OUTPUT_WIDTH  (OW),
        .ERR_CNT_WIDTH (EW)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .value_i   (value_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .mode_i    (mode_i),
        .en_out_i  (en_out_i),
        .code_o    (code_o),
        .oor_o     (oor_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .clr_err_i (clr_err_i),
        .err_cnt_o (err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] code;
        logic          oor;
    } ent_t;

    ent_t q[$];
    int   model_cnt = 0;
    int   n_checks  = 0;
    int   n_pass    = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic ent_t model_encode(input int v, input bit m, input bit en);
        ent_t        e;
        int unsigned r;
        e.oor = (v >= OW);
        r     = 0;
        if (!e.oor && en) begin
`ifdef ONE_HOT_ENC_THERMO_EN
            r = m ? ((32'd1 << (v + 1)) - 1) : (32'd1 << v);
`else
            r = 32'd1 << v;
`endif
        end
        e.code = r[OW-1:0];
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        ent_t exp_head;
        exp_head = (q.size() > 0) ? q[0] : '0;
        check({tag, ".valid"}, valid_o, q.size() > 0);
        check({tag, ".ready"}, ready_o, q.size() < 2);
        check({tag, ".code"},  code_o,  exp_head.code);
        check({tag, ".oor"},   oor_o,   exp_head.oor);
        check({tag, ".err"},   err_cnt_o, model_cnt);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare #1 later.
    task automatic cycle(input string tag, input bit v, input int val, input bit m,
                         input bit en, input bit rdy, input bit clr);
        bit   push;
        bit   pop;
        ent_t e;
        valid_i   = v;
        value_i   = val[IW-1:0];
        mode_i    = m;
        en_out_i  = en;
        ready_i   = rdy;
        clr_err_i = clr;
        push = v && (q.size() < 2);
        pop  = (q.size() > 0) && rdy;
        e    = model_encode(val, m, en);
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
        if (clr) model_cnt = 0;
        else if (push && e.oor && model_cnt < (1 << EW) - 1) model_cnt++;
        check_outputs(tag);
    endtask

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; value_i = '0; mode_i = 1'b0;
        en_out_i = 1'b1; ready_i = 1'b1; clr_err_i = 1'b0;
        #7;
        check_outputs("reset");
        #5;
        rst_ni = 1'b1;

        // First edge after release accepts; one-cycle latency.
        cycle("onehot5", 1, 5, 0, 1, 1, 0);
        check("onehot5.const", code_o, 32'h020);
        cycle("drain", 0, 0, 0, 1, 1, 0);

        cycle("mode1_v3", 1, 3, 1, 1, 1, 0);
`ifdef ONE_HOT_ENC_THERMO_EN
        check("thermo3.const", code_o, 32'h00F);
`else
        check("mode_ignored.const", code_o, 32'h008);
`endif
        cycle("en0_v3", 1, 3, 1, 0, 1, 0);
        check("en0.const", code_o, 32'h000);
        cycle("thermo11", 1, 11, 1, 1, 1, 0);
        cycle("onehot0", 1, 0, 0, 1, 1, 0);
        cycle("drain", 0, 0, 0, 1, 1, 0);

        // Out-of-range: zero code, oor flag, counter saturates at 3.
        cycle("oor13", 1, 13, 0, 1, 1, 0);
        check("oor13.oor.const", oor_o, 1);
        check("oor13.err.const", err_cnt_o, 1);
        for (int i = 0; i < 4; i++) cycle("oor_sat", 1, 12 + i, i % 2, i % 3 == 0, 1, 0);
        check("oor_sat.const", err_cnt_o, 3);
        cycle("clr_vs_inc", 1, 14, 0, 1, 1, 1);
        check("clr_vs_inc.const", err_cnt_o, 0);
        cycle("drain", 0, 0, 0, 1, 1, 0);

        // Backpressure: third push is refused while FULL.
        cycle("bp1", 1, 1, 0, 1, 0, 0);
        cycle("bp2", 1, 2, 0, 1, 0, 0);
        check("bp_full.const", ready_o, 0);
        cycle("bp3", 1, 3, 0, 1, 0, 0);
        cycle("bp_pop1", 0, 0, 0, 1, 1, 0);
        check("bp_pop1.const", code_o, 32'h004);
        check("bp_ready.const", ready_o, 1);
        cycle("bp_pop2", 0, 0, 0, 1, 1, 0);

        // Streaming in state ONE: push+pop every cycle.
        cycle("stream_fill", 1, 0, 0, 1, 1, 0);
        for (int i = 1; i <= 8; i++) cycle("stream", 1, i, 0, 1, 1, 0);
        cycle("stream_drain", 0, 0, 0, 1, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            cycle("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
        end

        // Fill to FULL with a non-zero error count, then reset mid-cycle.
        cycle("pre_rst_oor", 1, 15, 0, 1, 1, 0);
        cycle("pre_rst_a", 1, 7, 0, 1, 0, 0);
        cycle("pre_rst_b", 1, 9, 0, 1, 0, 0);
        valid_i = 1'b0;
        #3;
        rst_ni = 1'b0;
        #1;
        q.delete();
        model_cnt = 0;
        check_outputs("async_rst");
        #2;
        rst_ni = 1'b1;
        cycle("post_rst_idle", 0, 0, 0, 1, 0, 0);
        cycle("post_rst_push", 1, 4, 0, 1, 1, 0);
        check("post_rst.const", code_o, 32'h010);
        cycle("post_rst_drain", 0, 0, 0, 1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
